// File: rtl/lfsr_xnor.sv
// Maximal-length Fibonacci LFSR with XNOR feedback, seed load and a
// combinational done flag that fires when the state matches the seed input.
module lfsr_xnor #(
  parameter int NUM_BITS = 4
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Done
);

  function automatic logic [31:0] tap(input int t);
    return 32'd1 << (t - 1);
  endfunction

  // Tap positions are 1-based; tap t lands on bit t-1 of the mask.
  function automatic logic [31:0] tap_mask(input int n);
    logic [31:0] m;
    m = '0;
    case (n)
      3:  m = tap(3)  | tap(2);
      4:  m = tap(4)  | tap(3);
      5:  m = tap(5)  | tap(3);
      6:  m = tap(6)  | tap(5);
      7:  m = tap(7)  | tap(6);
      8:  m = tap(8)  | tap(6)  | tap(5) | tap(4);
      9:  m = tap(9)  | tap(5);
      10: m = tap(10) | tap(7);
      11: m = tap(11) | tap(9);
      12: m = tap(12) | tap(6)  | tap(4) | tap(1);
      13: m = tap(13) | tap(4)  | tap(3) | tap(1);
      14: m = tap(14) | tap(5)  | tap(3) | tap(1);
      15: m = tap(15) | tap(14);
      16: m = tap(16) | tap(15) | tap(13) | tap(4);
      17: m = tap(17) | tap(14);
      18: m = tap(18) | tap(11);
      19: m = tap(19) | tap(6)  | tap(2) | tap(1);
      20: m = tap(20) | tap(17);
      21: m = tap(21) | tap(19);
      22: m = tap(22) | tap(21);
      23: m = tap(23) | tap(18);
      24: m = tap(24) | tap(23) | tap(22) | tap(17);
      25: m = tap(25) | tap(22);
      26: m = tap(26) | tap(6)  | tap(2) | tap(1);
      27: m = tap(27) | tap(5)  | tap(2) | tap(1);
      28: m = tap(28) | tap(25);
      29: m = tap(29) | tap(27);
      30: m = tap(30) | tap(6)  | tap(4) | tap(1);
      31: m = tap(31) | tap(28);
      32: m = tap(32) | tap(22) | tap(2) | tap(1);
      default: m = '0;
    endcase
    return m;
  endfunction

  generate
    if (NUM_BITS < 3 || NUM_BITS > 32) begin : g_bad_width
      $error("lfsr_xnor: NUM_BITS must be in 3..32");
    end
  endgenerate

  localparam logic [31:0]         TAP_MASK = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS     = TAP_MASK[NUM_BITS-1:0];

  logic [NUM_BITS-1:0] r_LFSR;
  logic                w_fb;

  // All tap sets have an even member count, so all-ones maps to itself.
  assign w_fb = ~^(r_LFSR & TAPS);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_LFSR <= '0;
    end else if (i_Enable) begin
      if (i_Seed_DV) begin
        r_LFSR <= i_Seed_Data;
      end else begin
        r_LFSR <= {r_LFSR[NUM_BITS-2:0], w_fb};
      end
    end
  end

  assign o_LFSR_Data = r_LFSR;
  assign o_LFSR_Done = (r_LFSR == i_Seed_Data);

endmodule

// File: tb/tb_lfsr_xnor.sv
// Self-checking bench for lfsr_xnor: directed and random stimulus on a 4-bit
// instance against a tap-list reference model, plus period sweeps at 3/8/16/32.
module tb_lfsr_xnor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference next-state: shift left, new LSB = 1 when an even number of taps are set.
  function automatic longint model_next(input int n, input longint s);
    int taps[$];
    int ones;
    longint mask;
    case (n)
      3:  taps = '{3, 2};
      4:  taps = '{4, 3};
      8:  taps = '{8, 6, 5, 4};
      16: taps = '{16, 15, 13, 4};
      32: taps = '{32, 22, 2, 1};
      default: taps = '{};
    endcase
    ones = 0;
    foreach (taps[k]) ones += int'((s >> (taps[k] - 1)) & 64'd1);
    mask = (64'd1 << n) - 64'd1;
    return ((s << 1) | ((ones % 2 == 0) ? 64'd1 : 64'd0)) & mask;
  endfunction

  // 4-bit instance under directed/random test
  logic       rst_n, en, dv;
  logic [3:0] seed, data;
  logic       done;
  longint     m;

  lfsr_xnor #(.NUM_BITS(4)) u_dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en), .i_Seed_DV(dv),
    .i_Seed_Data(seed), .o_LFSR_Data(data), .o_LFSR_Done(done)
  );

  // Width sweep instances, free-running from reset with seed 0
  logic        sw_rst_n;
  logic [2:0]  d3;
  logic [7:0]  d8;
  logic [15:0] d16;
  logic [31:0] d32;
  logic        dn3, dn8, dn16, dn32;

  lfsr_xnor #(.NUM_BITS(3)) u_w3 (
    .i_Clk(clk), .i_Rst_n(sw_rst_n), .i_Enable(1'b1), .i_Seed_DV(1'b0),
    .i_Seed_Data(3'd0), .o_LFSR_Data(d3), .o_LFSR_Done(dn3)
  );
  lfsr_xnor #(.NUM_BITS(8)) u_w8 (
    .i_Clk(clk), .i_Rst_n(sw_rst_n), .i_Enable(1'b1), .i_Seed_DV(1'b0),
    .i_Seed_Data(8'd0), .o_LFSR_Data(d8), .o_LFSR_Done(dn8)
  );
  lfsr_xnor #(.NUM_BITS(16)) u_w16 (
    .i_Clk(clk), .i_Rst_n(sw_rst_n), .i_Enable(1'b1), .i_Seed_DV(1'b0),
    .i_Seed_Data(16'd0), .o_LFSR_Data(d16), .o_LFSR_Done(dn16)
  );
  lfsr_xnor #(.NUM_BITS(32)) u_w32 (
    .i_Clk(clk), .i_Rst_n(sw_rst_n), .i_Enable(1'b1), .i_Seed_DV(1'b0),
    .i_Seed_Data(32'd0), .o_LFSR_Data(d32), .o_LFSR_Done(dn32)
  );

  // Apply inputs, let one rising edge pass, then check state and done.
  task automatic step(input bit e, input bit d, input logic [3:0] s);
    en = e; dv = d; seed = s;
    @(posedge clk);
    if (e) m = d ? longint'(s) : model_next(4, m);
    @(negedge clk);
    chk("data", data, m);
    chk("done", done, (m == longint'(s)) ? 1 : 0);
  endtask

  bit sweep_done = 1'b0;

  initial begin : main_seq
    logic [3:0] exp_seq [15];
    exp_seq = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
                4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};
    rst_n = 1'b0; en = 1'b1; dv = 1'b0; seed = 4'h0; m = 0;
    repeat (2) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_done", done, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(1, 0, 4'h0);
      chk("seq", data, exp_seq[i]);
    end
    for (int i = 0; i < 15; i++) step(1, 0, 4'h0);

    step(1, 1, 4'hA);
    chk("load", data, 4'hA);
    step(1, 0, 4'hA);
    chk("load+1", data, 4'h4);
    step(1, 0, 4'hA);
    chk("load+2", data, 4'h8);
    for (int i = 0; i < 14; i++) step(1, 0, 4'hA);

    for (int i = 0; i < 5; i++) step(0, 1'($urandom % 2), 4'($urandom));
    for (int i = 0; i < 10; i++) step(1, 0, 4'hA);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", data, 0);
    m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 4'h0); chk("restart1", data, 4'h1);
    step(1, 0, 4'h0); chk("restart2", data, 4'h3);
    step(1, 0, 4'h0); chk("restart3", data, 4'h7);

    seed = 4'h7;
    #1 chk("done_comb_hi", done, 1);
    seed = 4'h3;
    #1 chk("done_comb_lo", done, 0);

    @(negedge clk);
    step(1, 1, 4'hF);
    for (int i = 0; i < 6; i++) step(1, 0, 4'hF);
    chk("lockup", data, 4'hF);

    step(1, 1, 4'h0);
    for (int i = 0; i < 300; i++)
      step(($urandom % 4) != 0, ($urandom % 8) == 0, 4'($urandom % 15));

    wait (sweep_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  bit     seen3 [8];
  bit     seen8 [256];
  bit     seen16[65536];

  initial begin : sweep
    int p3, p8, p16, r3, r8, r16;
    longint m32;
    p3 = 0; p8 = 0; p16 = 0; r3 = 0; r8 = 0; r16 = 0; m32 = 0;
    sw_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    seen3[0] = 1'b1; seen8[0] = 1'b1; seen16[0] = 1'b1;
    sw_rst_n = 1'b1;
    for (int c = 1; c <= 65540; c++) begin
      @(negedge clk);
      if (p3 == 0) begin
        if (d3 == 0) p3 = c;
        else begin if (seen3[d3]) r3++; seen3[d3] = 1'b1; end
      end
      if (p8 == 0) begin
        if (d8 == 0) p8 = c;
        else begin if (seen8[d8]) r8++; seen8[d8] = 1'b1; end
      end
      if (p16 == 0) begin
        if (d16 == 0) p16 = c;
        else begin if (seen16[d16]) r16++; seen16[d16] = 1'b1; end
      end
      if (c <= 2000) begin
        m32 = model_next(32, m32);
        chk("w32_state", d32, m32);
      end
    end
    chk("period3", p3, 7);
    chk("period8", p8, 255);
    chk("period16", p16, 65535);
    chk("repeat3", r3, 0);
    chk("repeat8", r8, 0);
    chk("repeat16", r16, 0);
    sweep_done = 1'b1;
  end

endmodule
